// File: rtl/cache_data_store.sv
// cache_data_store
//   Instruction cache data array: 2 lines x 2 ways x 8 words x 8 bits, with one
//   valid bit per line/way. A sequencer fills a way with eight in-order word writes.
//   A small fill FSM checks that sequence, sets the way's valid bit once the fill
//   completes and raises a sticky error flag on any protocol violation.
//
// Ports
//   clk            in   system clock, rising edge
//   sync_reset     in   synchronous active-high reset
//   cache_wren     in   fill write strobe
//   cache_wrline   in   fill line index
//   cache_wrentry  in   fill way index
//   cache_wroffset in   fill word offset [2:0]
//   rom_data       in   fill data [7:0]
//   cache_rdline   in   read line index
//   cache_rdentry  in   read way index
//   cache_rdoffset in   read word offset [2:0]
//   pm_data        out  read data [7:0] (combinational, forwarded, 0 when invalid)
//   rd_valid       out  valid bit of the addressed line/way
//   fill_active    out  fill FSM in FILL
//   fill_done      out  one-cycle pulse after the eighth word
//   fill_err       out  sticky protocol-violation flag
module cache_data_store (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic       cache_wren,
    input  logic       cache_wrline,
    input  logic       cache_wrentry,
    input  logic [2:0] cache_wroffset,
    input  logic [7:0] rom_data,
    input  logic       cache_rdline,
    input  logic       cache_rdentry,
    input  logic [2:0] cache_rdoffset,
    output logic [7:0] pm_data,
    output logic       rd_valid,
    output logic       fill_active,
    output logic       fill_done,
    output logic       fill_err
);

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    state_e     state_q, state_d;
    logic [2:0] exp_off_q, exp_off_d;
    logic       fill_line_q, fill_line_d;
    logic       fill_way_q, fill_way_d;
    logic [3:0] valid_q, valid_d;
    logic       err_q, err_d;
    logic [7:0] mem_q [32];

    logic [4:0] wr_addr, rd_addr;
    logic [1:0] wr_way_idx, rd_way_idx, fill_idx;
    logic       fwd;

    assign wr_way_idx = {cache_wrline, cache_wrentry};
    assign rd_way_idx = {cache_rdline, cache_rdentry};
    assign fill_idx   = {fill_line_q, fill_way_q};
    assign wr_addr    = {wr_way_idx, cache_wroffset};
    assign rd_addr    = {rd_way_idx, cache_rdoffset};

    always_comb begin
        state_d     = state_q;
        exp_off_d   = exp_off_q;
        fill_line_d = fill_line_q;
        fill_way_d  = fill_way_q;
        valid_d     = valid_q;
        err_d       = err_q;
        unique case (state_q)
            // DONE lasts one cycle and accepts new writes exactly like IDLE, so a
            // back-to-back fill can start on the same edge that validates the old one.
            StIdle, StDone: begin
                state_d = StIdle;
                if (state_q == StDone) begin
                    valid_d[fill_idx] = 1'b1;
                end
                if (cache_wren) begin
                    if (cache_wroffset == 3'd0) begin
                        state_d     = StFill;
                        fill_line_d = cache_wrline;
                        fill_way_d  = cache_wrentry;
                        exp_off_d   = 3'd1;
                        // Applied after the DONE set: refilling the same way invalidates it.
                        valid_d[wr_way_idx] = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StFill: begin
                if (cache_wren && cache_wroffset == exp_off_q &&
                    cache_wrline == fill_line_q && cache_wrentry == fill_way_q) begin
                    exp_off_d = exp_off_q + 3'd1;
                    if (cache_wroffset == 3'd7) begin
                        state_d = StDone;
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q     <= StIdle;
            exp_off_q   <= 3'd0;
            fill_line_q <= 1'b0;
            fill_way_q  <= 1'b0;
            valid_q     <= 4'b0000;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_off_q   <= exp_off_d;
            fill_line_q <= fill_line_d;
            fill_way_q  <= fill_way_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    // Data array is never cleared; the valid bits gate what is visible.
    always_ff @(posedge clk) begin
        if (!sync_reset && cache_wren) begin
            mem_q[wr_addr] <= rom_data;
        end
    end

    assign fwd = cache_wren && (wr_addr == rd_addr);

    always_comb begin
        pm_data = 8'h00;
        if (fwd) begin
            pm_data = rom_data;
        end else if (valid_q[rd_way_idx]) begin
            pm_data = mem_q[rd_addr];
        end
    end

    assign rd_valid    = valid_q[rd_way_idx];
    assign fill_active = (state_q == StFill);
    assign fill_done   = (state_q == StDone);
    assign fill_err    = err_q;

endmodule

// File: tb/tb_cache_data_store.sv
// tb_cache_data_store
//   Directed bench for cache_data_store. The stimulus process drives one cycle of
//   inputs just after each rising edge and pushes the hand-computed outputs for that
//   cycle into a scoreboard queue; a monitor pops and compares on the falling edge.
module tb_cache_data_store;

    logic       clk = 1'b0;
    logic       sync_reset = 1'b1;
    logic       cache_wren = 1'b0;
    logic       cache_wrline = 1'b0;
    logic       cache_wrentry = 1'b0;
    logic [2:0] cache_wroffset = 3'd0;
    logic [7:0] rom_data = 8'h00;
    logic       cache_rdline = 1'b0;
    logic       cache_rdentry = 1'b0;
    logic [2:0] cache_rdoffset = 3'd0;
    logic [7:0] pm_data;
    logic       rd_valid, fill_active, fill_done, fill_err;

    cache_data_store dut (
        .clk            (clk),
        .sync_reset     (sync_reset),
        .cache_wren     (cache_wren),
        .cache_wrline   (cache_wrline),
        .cache_wrentry  (cache_wrentry),
        .cache_wroffset (cache_wroffset),
        .rom_data       (rom_data),
        .cache_rdline   (cache_rdline),
        .cache_rdentry  (cache_rdentry),
        .cache_rdoffset (cache_rdoffset),
        .pm_data        (pm_data),
        .rd_valid       (rd_valid),
        .fill_active    (fill_active),
        .fill_done      (fill_done),
        .fill_err       (fill_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pm;
        logic       v;
        logic       act;
        logic       done;
        logic       err;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input string f, input logic [7:0] got,
                       input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s.%s: got %h want %h (t=%0t)", nm, f, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.nm, "pm_data", pm_data, e.pm);
            chk(e.nm, "rd_valid", {7'b0, rd_valid}, {7'b0, e.v});
            chk(e.nm, "fill_active", {7'b0, fill_active}, {7'b0, e.act});
            chk(e.nm, "fill_done", {7'b0, fill_done}, {7'b0, e.done});
            chk(e.nm, "fill_err", {7'b0, fill_err}, {7'b0, e.err});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic wl, input logic ww, input logic [2:0] wo,
                         input logic [7:0] wd, input logic rl, input logic rw,
                         input logic [2:0] ro);
        cache_wren     = we;
        cache_wrline   = wl;
        cache_wrentry  = ww;
        cache_wroffset = wo;
        rom_data       = wd;
        cache_rdline   = rl;
        cache_rdentry  = rw;
        cache_rdoffset = ro;
    endtask

    task automatic expect_out(input logic [7:0] pm, input logic v, input logic act,
                              input logic done, input logic err, input string nm);
        exp_t e;
        e.pm   = pm;
        e.v    = v;
        e.act  = act;
        e.done = done;
        e.err  = err;
        e.nm   = nm;
        sb.push_back(e);
    endtask

    // One reset cycle with the write port idle; nothing checked during it.
    task automatic do_reset();
        tick();
        sync_reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0);
        tick();
        sync_reset = 1'b0;
    endtask

    initial begin
        // Power-up reset held over two edges.
        tick();
        tick();
        sync_reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd5);
        expect_out(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "reset");

        // Clean fill of line 0 way 1 with A0..A7, reading offset 5 throughout.
        for (int k = 0; k < 8; k++) begin
            tick();
            drive(1'b1, 1'b0, 1'b1, k[2:0], 8'(8'hA0 + k), 1'b0, 1'b1, 3'd5);
            expect_out((k == 5) ? 8'hA5 : 8'h00, 1'b0, (k >= 1), 1'b0, 1'b0, "fill01");
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd5);
        expect_out(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "fill01_done");
        tick();
        expect_out(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, "fill01_rd5");
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd0);
        expect_out(8'hA0, 1'b1, 1'b0, 1'b0, 1'b0, "fill01_rd0");
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd7);
        expect_out(8'hA7, 1'b1, 1'b0, 1'b0, 1'b0, "fill01_rd7");

        // Aborted fill of line 1 way 1: strobe drops after offset 4.
        for (int k = 0; k < 5; k++) begin
            tick();
            drive(1'b1, 1'b1, 1'b1, k[2:0], 8'(8'h50 + k), 1'b1, 1'b1, 3'd2);
            expect_out((k == 2) ? 8'h52 : 8'h00, 1'b0, (k >= 1), 1'b0, 1'b0, "abort11");
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd2);
        expect_out(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "abort11_gap");
        tick();
        expect_out(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "abort11_err");
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd5);
        expect_out(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, "abort11_other");

        // Reset clears valid and error; stale data stays hidden.
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd5);
        expect_out(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "rst_hidden");

        // Write in IDLE at nonzero offset: forwarded, flagged, no valid.
        tick();
        drive(1'b1, 1'b1, 1'b1, 3'd4, 8'h77, 1'b1, 1'b1, 3'd4);
        expect_out(8'h77, 1'b0, 1'b0, 1'b0, 1'b0, "idle_bad_fwd");
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd4);
        expect_out(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "idle_bad_err");
        do_reset();

        // Out-of-order offsets 0,1,3 on line 0 way 0.
        tick();
        drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h10, 1'b1, 1'b0, 3'd0);
        expect_out(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "ooo_0");
        tick();
        drive(1'b1, 1'b0, 1'b0, 3'd1, 8'h11, 1'b1, 1'b0, 3'd0);
        expect_out(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "ooo_1");
        tick();
        drive(1'b1, 1'b0, 1'b0, 3'd3, 8'h13, 1'b1, 1'b0, 3'd0);
        expect_out(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "ooo_3");
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd0);
        expect_out(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "ooo_err");
        do_reset();

        // Fill of line 1 way 0 interrupted by reset at offset 2, then a clean refill.
        for (int k = 0; k < 2; k++) begin
            tick();
            drive(1'b1, 1'b1, 1'b0, k[2:0], 8'hEE, 1'b1, 1'b0, 3'd6);
            expect_out(8'h00, 1'b0, (k >= 1), 1'b0, 1'b0, "rstmid");
        end
        tick();
        sync_reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'd2, 8'hEE, 1'b1, 1'b0, 3'd6);
        for (int k = 0; k < 8; k++) begin
            tick();
            sync_reset = 1'b0;
            drive(1'b1, 1'b1, 1'b0, k[2:0], 8'(8'hB0 + k), 1'b1, 1'b0, 3'd6);
            expect_out((k == 6) ? 8'hB6 : 8'h00, 1'b0, (k >= 1), 1'b0, 1'b0, "fill10");
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd6);
        expect_out(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "fill10_done");
        tick();
        expect_out(8'hB6, 1'b1, 1'b0, 1'b0, 1'b0, "fill10_rd6");
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0);
        expect_out(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "fill10_w00");
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd5);
        expect_out(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "fill10_w01");
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd4);
        expect_out(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "fill10_w11");

        // Back-to-back: line 0 way 0, then way 1 starting in DONE, 3C at offset 3.
        for (int k = 0; k < 8; k++) begin
            tick();
            drive(1'b1, 1'b0, 1'b0, k[2:0], 8'(8'hC0 + k), 1'b0, 1'b1, 3'd3);
            expect_out(8'h00, 1'b0, (k >= 1), 1'b0, 1'b0, "b2b_a");
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            drive(1'b1, 1'b0, 1'b1, k[2:0], (k == 3) ? 8'h3C : 8'(8'hD0 + k),
                  1'b0, 1'b1, 3'd3);
            expect_out((k == 3) ? 8'h3C : 8'h00, 1'b0, (k >= 1), (k == 0), 1'b0, "b2b_b");
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd3);
        expect_out(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_done");
        tick();
        expect_out(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, "b2b_rd01");
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd7);
        expect_out(8'hC7, 1'b1, 1'b0, 1'b0, 1'b0, "b2b_rd00");
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd6);
        expect_out(8'hB6, 1'b1, 1'b0, 1'b0, 1'b0, "b2b_rd10");
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd4);
        expect_out(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_rd11");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 4 && sb.size() > 0; i++) begin
            tick();
        end
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
